avalon_master_arbiter: RTL and testbench
========================================

# avalon_master_arbiter

Two-requester arbiter that shares the single Avalon-MM master port between the SPI bridge state machine and a second bridge (debug/UART). Each requester uses the level-held read/write + ack handshake that the SPI bridge already uses. The arbiter converts that handshake to Avalon-MM (waitrequest/readdatavalid), grants round-robin, and guards the bus with a response timeout.

## Interface
Parameters:
- `TIMEOUT`, 1024: cycles allowed from command issue to completion before an error ack is returned.
- `ERR_DATA`, 32'hDEADBEEF: read data returned on timeout.

Ports:
- `clock`  in  1  single clock; all logic synchronous to its rising edge.
- `nreset`  in  1  reset, synchronous, active-low.
- `rN_read` / `rN_write`  in  1 each  request level for N∈{0,1}; held until `rN_ack` is seen.
- `rN_address`  in  32  byte address; stable while the request is held.
- `rN_byte_enable`  in  4  byte lanes.
- `rN_write_data`  in  32  write data.
- `rN_ack`  out  1  completion; held high until the requester drops read/write.
- `rN_read_data`  out  32  read data; valid while `rN_ack`=1.
- `rN_error`  out  1  timeout flag; valid while `rN_ack`=1.
- `avm_address`, `avm_byteenable`, `avm_writedata`, `avm_read`, `avm_write`  out  32/4/32/1/1  Avalon-MM command.
- `avm_waitrequest`, `avm_readdatavalid`  in  1 each; `avm_readdata`  in  32.
- `grant`  out  2  one-hot owner; 0 when idle.

## Operation
- States (one-hot): IDLE, ISSUE, WAIT_DATA, ACK.
- IDLE: if either requester has read|write high, grant it. If both are high, grant the one not in `last_grant`. Latch address, byte_enable, write_data and direction into command registers, clear the timeout counter, and go to ISSUE. If read and write are both high, perform the read and ignore the write.
- ISSUE: drive `avm_read` or `avm_write` with the latched command. When `avm_waitrequest`=0 the command is accepted and drops the next cycle. After acceptance a write goes to ACK and a read goes to WAIT_DATA.
- WAIT_DATA: on `avm_readdatavalid`, capture `avm_readdata` into the granted `rN_read_data` and go to ACK.
- ACK: granted `rN_ack`=1 and `rN_error` reflects timeout. When the granted requester has read and write both low, clear ack/error, set `last_grant`←owner, clear `grant`, and return to IDLE.
- Timeout: the counter increments in ISSUE and WAIT_DATA. At `TIMEOUT-1`, deassert the command, set error=1, set read_data=`ERR_DATA` (writes too), and go to ACK.
- Abort in ISSUE: if the requester drops read/write before acceptance, drop the command and return to IDLE with no ack.
- Abort in WAIT_DATA: the transaction stays outstanding. Wait for readdatavalid or timeout, enter ACK, and leave on the next cycle because the request is already low.
- `avm_readdatavalid` outside WAIT_DATA is ignored. This covers late responses after a timeout or reset.
- The non-granted requester is not observed and its outputs stay 0, except `rN_read_data`, which holds its last value.

## Timing
- Reset values: all `rN_ack`/`rN_error`=0, `rN_read_data`=0, `avm_read`/`avm_write`=0, `avm_*` command=0, `grant`=0, state IDLE, `last_grant`=1 (requester 0 wins the first tie).
- Reset asserted mid-transaction returns to IDLE on the next edge. Commands drop immediately and no ack is issued.
- Request high at cycle 0 → `avm_read`/`avm_write` high at cycle 1 (registered).
- Write accepted at cycle k → `rN_ack` high at k+1.
- Read: readdatavalid at cycle j → `rN_ack` and data at j+1.
- Requester drops request at cycle m → `rN_ack` low at m+1. The other requester can be issued at m+2.
- Timeout with no acceptance: command high cycles 1..TIMEOUT, ack at TIMEOUT+1.
- Counter width is $clog2(TIMEOUT+1); it saturates and never wraps.

## Structure
- `avalon_arb_pkg`: state encoding constants (IDLE=4'b0001, ISSUE=4'b0010, WAIT_DATA=4'b0100, ACK=4'b1000) and the `ERR_DATA` default.
- Sub-module `rr_grant2`: combinational 2-way round-robin pick from {req0, req1, last_grant} giving a one-hot grant.
- The remainder is one FSM with command registers, counter and per-requester output registers.

## Test plan
- r0 write addr 0x10, data 0x12345678, waitrequest low → avm_write cycle 1 only, r0_ack at 2, held until r0_write low, error=0.
- r1 read addr 0x20, waitrequest 3 cycles, readdatavalid 2 cycles after accept with 0xCAFEF00D → r1_read_data=0xCAFEF00D, r1_ack one cycle after valid.
- r0 and r1 request in the same cycle twice in succession → grant order r0, r1, then r0 again on the next tie.
- TIMEOUT=16, read never answered → r0_ack at cycle 17 with error=1 and data 0xDEADBEEF; a late readdatavalid is ignored.
- r1 drops read during ISSUE → command removed the next cycle, no ack, r0 request served next.
- nreset low during WAIT_DATA → all outputs 0 the next cycle and a subsequent readdatavalid produces no ack.

Source files
------------

// File: rtl/avalon_arb_pkg.sv
// avalon_arb_pkg: shared state encoding and defaults for the Avalon master arbiter
package avalon_arb_pkg;
   typedef enum logic [3:0] {
      IDLE      = 4'b0001,
      ISSUE     = 4'b0010,
      WAIT_DATA = 4'b0100,
      ACK       = 4'b1000
   } state_t;
   localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;
endpackage

// File: rtl/rr_grant2.sv
// rr_grant2: two-way round-robin pick; on a tie the requester that was not last served wins
module rr_grant2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] grant
);
   assign grant = (req == 2'b11) ? (last_grant ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/avalon_master_arbiter.sv
// avalon_master_arbiter: shares one Avalon-MM master between two level/ack requesters with a response timeout
module avalon_master_arbiter
   import avalon_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT  = 1024,
   parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
   input  logic        clock,
   input  logic        nreset,
   input  logic        r0_read,
   input  logic        r0_write,
   input  logic [31:0] r0_address,
   input  logic [3:0]  r0_byte_enable,
   input  logic [31:0] r0_write_data,
   output logic        r0_ack,
   output logic [31:0] r0_read_data,
   output logic        r0_error,
   input  logic        r1_read,
   input  logic        r1_write,
   input  logic [31:0] r1_address,
   input  logic [3:0]  r1_byte_enable,
   input  logic [31:0] r1_write_data,
   output logic        r1_ack,
   output logic [31:0] r1_read_data,
   output logic        r1_error,
   output logic [31:0] avm_address,
   output logic [3:0]  avm_byteenable,
   output logic [31:0] avm_writedata,
   output logic        avm_read,
   output logic        avm_write,
   input  logic        avm_waitrequest,
   input  logic        avm_readdatavalid,
   input  logic [31:0] avm_readdata,
   output logic [1:0]  grant
);
   localparam int CW = $clog2(TIMEOUT + 1);
   state_t state, state_n;
   logic [1:0] req, pick, ack, err;
   logic [31:0] rdata [2];
   logic [CW-1:0] cnt;
   logic last_grant, is_read, own, greq, sel_read, sel_write, busy;
   logic start, tmo, accept, abort, rvalid, done, set_ack;
   assign req = {r1_read | r1_write, r0_read | r0_write};
   rr_grant2 u_pick (.req(req), .last_grant(last_grant), .grant(pick));
   assign own       = grant[1];
   assign greq      = req[own];
   assign sel_read  = pick[1] ? r1_read : r0_read;
   assign sel_write = pick[1] ? r1_write : r0_write;
   assign busy      = state == ISSUE || state == WAIT_DATA;
   // A response arriving in the timeout cycle still wins; timeout beats a same-cycle acceptance
   assign start   = state == IDLE && |pick;
   assign rvalid  = state == WAIT_DATA && avm_readdatavalid;
   assign tmo     = busy && cnt >= CW'(TIMEOUT - 1) && !rvalid;
   assign accept  = state == ISSUE && !avm_waitrequest && !tmo;
   assign abort   = state == ISSUE && avm_waitrequest && !greq && !tmo;
   assign done    = state == ACK && !greq;
   assign set_ack = tmo || rvalid || (accept && !is_read);
   assign r0_ack       = ack[0];
   assign r1_ack       = ack[1];
   assign r0_error     = err[0];
   assign r1_error     = err[1];
   assign r0_read_data = rdata[0];
   assign r1_read_data = rdata[1];
   // Next-state selection
   always_comb begin
      state_n = state;
      case (state)
         IDLE:      state_n = start ? ISSUE : IDLE;
         ISSUE:     state_n = tmo ? ACK : accept ? (is_read ? WAIT_DATA : ACK) : abort ? IDLE : ISSUE;
         WAIT_DATA: state_n = (rvalid || tmo) ? ACK : WAIT_DATA;
         ACK:       state_n = done ? IDLE : ACK;
         default:   state_n = IDLE;
      endcase
   end
   // State register
   always_ff @(posedge clock)
      state <= !nreset ? IDLE : state_n;
   // Command, counter, grant and per-requester response registers
   always_ff @(posedge clock) begin
      if (!nreset) begin
         grant          <= '0;
         last_grant     <= 1'b1;
         is_read        <= 1'b0;
         cnt            <= '0;
         avm_address    <= '0;
         avm_byteenable <= '0;
         avm_writedata  <= '0;
         avm_read       <= 1'b0;
         avm_write      <= 1'b0;
         ack            <= '0;
         err            <= '0;
         rdata[0]       <= '0;
         rdata[1]       <= '0;
      end else begin
         if (busy && cnt != CW'(TIMEOUT))
            cnt <= cnt + 1'b1;
         if (start) begin
            grant          <= pick;
            is_read        <= sel_read;
            cnt            <= '0;
            avm_address    <= pick[1] ? r1_address : r0_address;
            avm_byteenable <= pick[1] ? r1_byte_enable : r0_byte_enable;
            avm_writedata  <= pick[1] ? r1_write_data : r0_write_data;
            avm_read       <= sel_read;
            avm_write      <= sel_write & ~sel_read;
         end
         if (accept || abort || tmo) begin
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
         end
         if (abort)
            grant <= '0;
         if (set_ack) begin
            ack[own] <= 1'b1;
            err[own] <= tmo;
            if (tmo)
               rdata[own] <= ERR_DATA;
            else if (rvalid)
               rdata[own] <= avm_readdata;
         end
         if (done) begin
            ack        <= '0;
            err        <= '0;
            last_grant <= own;
            grant      <= '0;
         end
      end
   end
endmodule

// File: tb/tb_avalon_master_arbiter.sv
// tb_avalon_master_arbiter: directed checks of handshake timing, round-robin, timeout, abort and reset
module tb_avalon_master_arbiter;
   logic        clock = 1'b0, nreset = 1'b0;
   logic        r0_read = 0, r0_write = 0, r1_read = 0, r1_write = 0;
   logic [31:0] r0_address = 0, r0_write_data = 0, r1_address = 0, r1_write_data = 0;
   logic [3:0]  r0_byte_enable = 0, r1_byte_enable = 0;
   logic        r0_ack, r0_error, r1_ack, r1_error;
   logic [31:0] r0_read_data, r1_read_data;
   logic [31:0] avm_address, avm_writedata, avm_readdata = 0;
   logic [3:0]  avm_byteenable;
   logic        avm_read, avm_write, avm_waitrequest = 0, avm_readdatavalid = 0;
   logic [1:0]  grant;
   int n_chk = 0, n_fail = 0;
   avalon_master_arbiter #(.TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) dut (
      .clock(clock), .nreset(nreset),
      .r0_read(r0_read), .r0_write(r0_write), .r0_address(r0_address),
      .r0_byte_enable(r0_byte_enable), .r0_write_data(r0_write_data),
      .r0_ack(r0_ack), .r0_read_data(r0_read_data), .r0_error(r0_error),
      .r1_read(r1_read), .r1_write(r1_write), .r1_address(r1_address),
      .r1_byte_enable(r1_byte_enable), .r1_write_data(r1_write_data),
      .r1_ack(r1_ack), .r1_read_data(r1_read_data), .r1_error(r1_error),
      .avm_address(avm_address), .avm_byteenable(avm_byteenable),
      .avm_writedata(avm_writedata), .avm_read(avm_read), .avm_write(avm_write),
      .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
      .avm_readdata(avm_readdata), .grant(grant)
   );
   always #5 clock = ~clock;
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   initial begin
      tick();
      tick();
      nreset = 1;
      check("rst_grant", 32'(grant), 0);
      check("rst_ack", {r1_ack, r0_ack, r1_error, r0_error}, 0);
      check("rst_cmd", {avm_read, avm_write}, 0);
      check("rst_addr", avm_address, 0);
      check("rst_rdata", r0_read_data | r1_read_data, 0);
      // r0 write, no wait states
      r0_write = 1; r0_address = 32'h10; r0_write_data = 32'h12345678; r0_byte_enable = 4'hF;
      tick();
      check("wr_c1_write", 32'(avm_write), 1);
      check("wr_c1_addr", avm_address, 32'h10);
      check("wr_c1_data", avm_writedata, 32'h12345678);
      check("wr_c1_be", 32'(avm_byteenable), 32'hF);
      check("wr_c1_grant", 32'(grant), 1);
      check("wr_c1_ack", 32'(r0_ack), 0);
      tick();
      check("wr_c2_write", 32'(avm_write), 0);
      check("wr_c2_ack", {r0_ack, r0_error}, 2'b10);
      tick();
      check("wr_c3_hold", 32'(r0_ack), 1);
      r0_write = 0;
      tick();
      check("wr_drop_ack", 32'(r0_ack), 0);
      check("wr_drop_grant", 32'(grant), 0);
      // r1 read, waitrequest for 3 cycles, data 2 cycles after accept
      r1_read = 1; r1_address = 32'h20; r1_byte_enable = 4'h3; avm_waitrequest = 1;
      tick();
      check("rd_c1_read", 32'(avm_read), 1);
      check("rd_c1_grant", 32'(grant), 2);
      check("rd_c1_addr", avm_address, 32'h20);
      tick();
      tick();
      check("rd_c3_read", 32'(avm_read), 1);
      tick();
      avm_waitrequest = 0;
      check("rd_c4_read", 32'(avm_read), 1);
      tick();
      check("rd_c5_read", 32'(avm_read), 0);
      check("rd_c5_ack", 32'(r1_ack), 0);
      tick();
      avm_readdatavalid = 1; avm_readdata = 32'hCAFEF00D;
      check("rd_c6_ack", 32'(r1_ack), 0);
      tick();
      avm_readdatavalid = 0;
      check("rd_c7_ack", {r1_ack, r1_error}, 2'b10);
      check("rd_c7_data", r1_read_data, 32'hCAFEF00D);
      check("rd_other_data", r0_read_data, 0);
      check("rd_other_ack", 32'(r0_ack), 0);
      r1_read = 0;
      tick();
      check("rd_drop_ack", 32'(r1_ack), 0);
      check("rd_hold_data", r1_read_data, 32'hCAFEF00D);
      // simultaneous requests: r0, then r1, then r0 again
      r0_write = 1; r0_address = 32'hA0; r1_write = 1; r1_address = 32'hB0;
      tick();
      check("tie1_grant", 32'(grant), 1);
      check("tie1_addr", avm_address, 32'hA0);
      tick();
      check("tie1_ack", {r1_ack, r0_ack}, 2'b01);
      r0_write = 0;
      tick();
      check("tie1_idle", 32'(grant), 0);
      tick();
      check("tie2_grant", 32'(grant), 2);
      check("tie2_addr", avm_address, 32'hB0);
      check("tie2_write", 32'(avm_write), 1);
      tick();
      check("tie2_ack", {r1_ack, r0_ack}, 2'b10);
      r1_write = 0;
      tick();
      r0_write = 1; r1_write = 1;
      tick();
      check("tie3_grant", 32'(grant), 1);
      tick();
      r0_write = 0; r1_write = 0;
      tick();
      tick();
      check("tie3_end", {30'd0, grant}, 0);
      // read never answered: timeout at TIMEOUT=16
      r0_read = 1; r0_address = 32'h40;
      tick();
      check("to_c1_read", 32'(avm_read), 1);
      tick();
      check("to_c2_read", 32'(avm_read), 0);
      for (int i = 3; i <= 16; i++) tick();
      check("to_c16_ack", 32'(r0_ack), 0);
      tick();
      check("to_c17_ack", {r0_ack, r0_error}, 2'b11);
      check("to_c17_data", r0_read_data, 32'hDEADBEEF);
      avm_readdatavalid = 1; avm_readdata = 32'h11111111;
      tick();
      avm_readdatavalid = 0;
      check("to_late_data", r0_read_data, 32'hDEADBEEF);
      r0_read = 0;
      tick();
      check("to_drop", {r0_ack, r0_error}, 0);
      avm_readdatavalid = 1;
      tick();
      avm_readdatavalid = 0;
      check("to_idle_valid", {r1_ack, r0_ack, grant}, 0);
      // r1 aborts during ISSUE, r0 served next
      r1_read = 1; r1_address = 32'h30; avm_waitrequest = 1;
      tick();
      check("ab_c1_read", 32'(avm_read), 1);
      check("ab_c1_grant", 32'(grant), 2);
      r1_read = 0; r0_write = 1; r0_address = 32'h50;
      tick();
      avm_waitrequest = 0;
      check("ab_c2_cmd", {avm_read, avm_write, grant}, 0);
      check("ab_c2_ack", 32'(r1_ack), 0);
      tick();
      check("ab_c3_grant", 32'(grant), 1);
      check("ab_c3_write", 32'(avm_write), 1);
      check("ab_c3_addr", avm_address, 32'h50);
      tick();
      check("ab_c4_ack", {r1_ack, r0_ack}, 2'b01);
      r0_write = 0;
      tick();
      // reset during WAIT_DATA
      r0_read = 1; r0_address = 32'h60;
      tick();
      tick();
      check("rs_wait_read", 32'(avm_read), 0);
      nreset = 0;
      tick();
      check("rs_cmd", {avm_read, avm_write, grant}, 0);
      check("rs_ack", 32'(r0_ack), 0);
      check("rs_data", r0_read_data, 0);
      nreset = 1; r0_read = 0; avm_readdatavalid = 1; avm_readdata = 32'h55;
      tick();
      avm_readdatavalid = 0;
      check("rs_late_ack", {r1_ack, r0_ack, grant}, 0);
      check("rs_late_data", r0_read_data, 0);
      tick();
      check("rs_after", 32'(r0_ack), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
